axim_stream_mem_resp: RTL and testbench

- Responder end of the vector memory subsystem's AXI-master control/stream interface.
- Sits where the AXI master adapter normally sits and serves the subsystem's ctrl_rstart/ctrl_wstart transfers from an on-chip word-addressed RAM.
- Used as a scratchpad and for stand-alone bring-up of the memory subsystem without an external AXI slave.
- Read and write channels are independent and may run concurrently.

---
 rtl/axim_stream_mem_resp.sv | 187 ++++++++++++++++++
 tb/tb_axim_stream_mem_resp.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axim_stream_mem_resp.sv
// Stream responder backed by an on-chip word RAM, serving ctrl_rstart/ctrl_wstart transfers.
// Optional backpressure injection via `define AXIM_STREAM_MEM_RESP_STALL_EN (8-bit LFSR stalls).
module axim_stream_mem_resp #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int MEM_DEPTH          = 4096
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_raddr_offset_i,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_rxfer_size_i,
  input  logic                          ctrl_rstart_i,
  output logic                          ctrl_rdone_o,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rd_tdata_o,
  output logic                          rd_tvalid_o,
  input  logic                          rd_tready_i,
  output logic                          rd_tlast_o,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_waddr_offset_i,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_wxfer_size_i,
  input  logic                          ctrl_wstart_i,
  output logic                          ctrl_wdone_o,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] wr_tdata_i,
  input  logic                          wr_tvalid_i,
  output logic                          wr_tready_o
);
  localparam int DW  = C_M_AXI_DATA_WIDTH;
  localparam int AW  = C_M_AXI_ADDR_WIDTH;
  localparam int XW  = C_XFER_SIZE_WIDTH;
  localparam int BPW = DW / 8;
  localparam int LG  = $clog2(BPW);
  localparam int IW  = $clog2(MEM_DEPTH);
  localparam logic [XW-1:0] LOW_MASK = XW'(BPW - 1);

  typedef enum logic [1:0] {R_IDLE, R_RUN, R_DRAIN, R_DONE} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_RUN, W_DONE} wstate_e;

  logic [DW-1:0] mem [MEM_DEPTH];
  logic [DW-1:0] ram_rdata_q;

  rstate_e rstate_q, rstate_d;
  wstate_e wstate_q, wstate_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic [XW-1:0] rissue_q, rissue_d, rbeat_q, rbeat_d, wbeat_q, wbeat_d;
  logic          inflight_q, inflight_d;
  logic [DW-1:0] fifo_q [2];
  logic [DW-1:0] fifo_d [2];
  logic          fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
  logic [1:0]    fifo_cnt_q, fifo_cnt_d;
  logic          stall;

  logic [AW-1:0] roff_sh, woff_sh;
  logic [IW-1:0] ridx_start, widx_start, rd_addr;
  logic [XW-1:0] rbeats_start, wbeats_start;
  logic [2:0]    rd_occ;
  logic          rd_start, rd_issue_run, rd_issue, rd_pop, wr_start, wr_hs;
  logic          unused_offset_bits;

  assign roff_sh      = ctrl_raddr_offset_i >> LG;
  assign woff_sh      = ctrl_waddr_offset_i >> LG;
  assign ridx_start   = roff_sh[IW-1:0];
  assign widx_start   = woff_sh[IW-1:0];
  assign unused_offset_bits = ^{roff_sh[AW-1:IW], woff_sh[AW-1:IW]};
  assign rbeats_start = (ctrl_rxfer_size_i >> LG) + XW'((ctrl_rxfer_size_i & LOW_MASK) != '0);
  assign wbeats_start = (ctrl_wxfer_size_i >> LG) + XW'((ctrl_wxfer_size_i & LOW_MASK) != '0);

`ifdef AXIM_STREAM_MEM_RESP_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign stall  = (lfsr_q[1:0] == 2'b00);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign stall = 1'b0;
`endif

  // Credit check counts this cycle's pop so a full pipe still sustains 1 beat/cycle.
  assign rd_occ       = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
  assign rd_pop       = rd_tvalid_o && rd_tready_i;
  assign rd_start     = (rstate_q == R_IDLE) && ctrl_rstart_i;
  assign rd_issue_run = (rstate_q == R_RUN) && (rissue_q != '0) &&
                        ((rd_occ < 3'd2) || ((rd_occ == 3'd2) && rd_pop));
  // The first read is issued straight from IDLE to meet the 2-cycle start-to-valid latency.
  assign rd_issue     = (rd_start && (rbeats_start != '0)) || rd_issue_run;
  assign rd_addr      = (rstate_q == R_IDLE) ? ridx_start : rd_idx_q;
  assign wr_start     = (wstate_q == W_IDLE) && ctrl_wstart_i;
  assign wr_hs        = wr_tready_o && wr_tvalid_i;

  // Read-first RAM: a same-cycle read of the word being written returns the old data.
  always_ff @(posedge clk) begin
    if (wr_hs)    mem[wr_idx_q] <= wr_tdata_i;
    if (rd_issue) ram_rdata_q   <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rstate_q   <= R_IDLE;
      wstate_q   <= W_IDLE;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      rissue_q   <= '0;
      rbeat_q    <= '0;
      wbeat_q    <= '0;
      inflight_q <= 1'b0;
      fifo_wp_q  <= 1'b0;
      fifo_rp_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      rstate_q   <= rstate_d;
      wstate_q   <= wstate_d;
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      rissue_q   <= rissue_d;
      rbeat_q    <= rbeat_d;
      wbeat_q    <= wbeat_d;
      inflight_q <= inflight_d;
      fifo_wp_q  <= fifo_wp_d;
      fifo_rp_q  <= fifo_rp_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo_q     <= fifo_d;
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (ctrl_rstart_i) rstate_d = (rbeats_start == '0) ? R_DONE : R_RUN;
      R_RUN:   if (rissue_d == '0) rstate_d = R_DRAIN;
      R_DRAIN: if (rd_pop && (rbeat_q == XW'(1))) rstate_d = R_DONE;
      default: rstate_d = R_IDLE;
    endcase
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if (ctrl_wstart_i) wstate_d = (wbeats_start == '0) ? W_DONE : W_RUN;
      W_RUN:   if (wr_hs && (wbeat_q == XW'(1))) wstate_d = W_DONE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_idx_d   = rd_idx_q;
    rissue_d   = rissue_q;
    rbeat_d    = rbeat_q;
    wr_idx_d   = wr_idx_q;
    wbeat_d    = wbeat_q;
    inflight_d = rd_issue;
    fifo_d     = fifo_q;
    fifo_wp_d  = fifo_wp_q;
    fifo_rp_d  = fifo_rp_q;
    fifo_cnt_d = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, rd_pop};
    if (rd_start) begin
      rd_idx_d = ridx_start + IW'(1);
      rissue_d = rbeats_start - XW'(rbeats_start != '0);
      rbeat_d  = rbeats_start;
    end else if (rd_issue_run) begin
      rd_idx_d = rd_idx_q + IW'(1);
      rissue_d = rissue_q - XW'(1);
    end
    if (rd_pop) begin
      rbeat_d   = rbeat_q - XW'(1);
      fifo_rp_d = ~fifo_rp_q;
    end
    if (inflight_q) begin
      fifo_d[fifo_wp_q] = ram_rdata_q;
      fifo_wp_d         = ~fifo_wp_q;
    end
    if (wr_start) begin
      wr_idx_d = widx_start;
      wbeat_d  = wbeats_start;
    end else if (wr_hs) begin
      wr_idx_d = wr_idx_q + IW'(1);
      wbeat_d  = wbeat_q - XW'(1);
    end
  end

  always_comb begin
    ctrl_rdone_o = (rstate_q == R_DONE);
    ctrl_wdone_o = (wstate_q == W_DONE);
    rd_tvalid_o  = (fifo_cnt_q != 2'd0) && !stall;
    rd_tdata_o   = fifo_q[fifo_rp_q];
    rd_tlast_o   = rd_tvalid_o && (rbeat_q == XW'(1));
    wr_tready_o  = (wstate_q == W_RUN) && !stall;
  end
endmodule

// File: tb/tb_axim_stream_mem_resp.sv
// Directed bench for axim_stream_mem_resp: write/read, backpressure, size 0, restart, reset, wrap.
module tb_axim_stream_mem_resp;
  localparam int D = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] ctrl_raddr_offset_i = '0, ctrl_rxfer_size_i = '0;
  logic        ctrl_rstart_i = 1'b0, ctrl_rdone_o;
  logic [31:0] rd_tdata_o;
  logic        rd_tvalid_o, rd_tready_i = 1'b0, rd_tlast_o;
  logic [31:0] ctrl_waddr_offset_i = '0, ctrl_wxfer_size_i = '0;
  logic        ctrl_wstart_i = 1'b0, ctrl_wdone_o;
  logic [31:0] wr_tdata_i = '0;
  logic        wr_tvalid_i = 1'b0, wr_tready_o;

  axim_stream_mem_resp #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
    .C_XFER_SIZE_WIDTH(32), .MEM_DEPTH(D)
  ) dut (
    .clk(clk), .rstn(rstn),
    .ctrl_raddr_offset_i(ctrl_raddr_offset_i), .ctrl_rxfer_size_i(ctrl_rxfer_size_i),
    .ctrl_rstart_i(ctrl_rstart_i), .ctrl_rdone_o(ctrl_rdone_o),
    .rd_tdata_o(rd_tdata_o), .rd_tvalid_o(rd_tvalid_o), .rd_tready_i(rd_tready_i),
    .rd_tlast_o(rd_tlast_o),
    .ctrl_waddr_offset_i(ctrl_waddr_offset_i), .ctrl_wxfer_size_i(ctrl_wxfer_size_i),
    .ctrl_wstart_i(ctrl_wstart_i), .ctrl_wdone_o(ctrl_wdone_o),
    .wr_tdata_i(wr_tdata_i), .wr_tvalid_i(wr_tvalid_i), .wr_tready_o(wr_tready_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0, total_cnt = 0;
  logic [31:0] wvec [16];
  logic [31:0] rq [$];
  logic        lq [$];
  int rdone_cnt, rdone_cyc, first_valid, stable_err, start_cyc;
  int hs_cnt, last_hs_cyc, wdone_cnt, wdone_cyc;

  task automatic run_write(input logic [31:0] off, input logic [31:0] size);
    logic took;
    hs_cnt = 0; wdone_cnt = 0; last_hs_cyc = -1; wdone_cyc = -1;
    @(posedge clk); #1;
    ctrl_waddr_offset_i = off; ctrl_wxfer_size_i = size; ctrl_wstart_i = 1'b1;
    wr_tvalid_i = 1'b1; wr_tdata_i = wvec[0];
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ctrl_wdone_o) begin wdone_cnt++; wdone_cyc = cyc; end
      took = wr_tready_o && wr_tvalid_i;
      if (took) last_hs_cyc = cyc;
      @(posedge clk); #1;
      ctrl_wstart_i = 1'b0;
      if (took) begin
        hs_cnt++;
        wr_tdata_i = wvec[hs_cnt % 16];
      end
    end
    wr_tvalid_i = 1'b0;
    $display("write off=0x%0h size=%0d handshakes=%0d done_pulses=%0d", off, size, hs_cnt, wdone_cnt);
  endtask

  task automatic run_read(input logic [31:0] off, input logic [31:0] size,
                          input int mode, input int restart_at);
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    rq.delete(); lq.delete();
    rdone_cnt = 0; rdone_cyc = -1; first_valid = -1; stable_err = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    @(posedge clk); #1;
    ctrl_raddr_offset_i = off; ctrl_rxfer_size_i = size; ctrl_rstart_i = 1'b1;
    rd_tready_i = 1'b1;
    start_cyc = cyc;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (ctrl_rdone_o) begin rdone_cnt++; rdone_cyc = cyc; end
      if (rd_tvalid_o && first_valid < 0) first_valid = cyc;
      if (prev_stall && rd_tvalid_o && (rd_tdata_o !== prev_data || rd_tlast_o !== prev_last))
        stable_err++;
      prev_stall = rd_tvalid_o && !rd_tready_i;
      prev_data  = rd_tdata_o;
      prev_last  = rd_tlast_o;
      if (rd_tvalid_o && rd_tready_i) begin rq.push_back(rd_tdata_o); lq.push_back(rd_tlast_o); end
      @(posedge clk); #1;
      ctrl_rstart_i = (k + 1 == restart_at);
      rd_tready_i   = (mode == 0) ? 1'b1 : (((k + 1) % 3) == 0);
    end
    rd_tready_i = 1'b0;
    $display("read off=0x%0h size=%0d beats=%0d done_pulses=%0d", off, size, rq.size(), rdone_cnt);
  endtask

  task automatic test_reset;
    @(negedge clk);
    total_cnt++; if (ctrl_rdone_o !== 1'b0) $display("FAIL reset_rdone got %b want 0", ctrl_rdone_o); else pass_cnt++;
    total_cnt++; if (rd_tvalid_o !== 1'b0) $display("FAIL reset_tvalid got %b want 0", rd_tvalid_o); else pass_cnt++;
    total_cnt++; if (rd_tlast_o !== 1'b0) $display("FAIL reset_tlast got %b want 0", rd_tlast_o); else pass_cnt++;
    total_cnt++; if (rd_tdata_o !== 32'h0) $display("FAIL reset_tdata got %h want 0", rd_tdata_o); else pass_cnt++;
    total_cnt++; if (ctrl_wdone_o !== 1'b0) $display("FAIL reset_wdone got %b want 0", ctrl_wdone_o); else pass_cnt++;
    total_cnt++; if (wr_tready_o !== 1'b0) $display("FAIL reset_wready got %b want 0", wr_tready_o); else pass_cnt++;
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  task automatic test_write_read_basic;
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
    for (int i = 0; i < 4; i++) wvec[i] = exp_d[i];
    run_write(32'h0, 32'd16);
    total_cnt++; if (hs_cnt != 4) $display("FAIL basic_write_hs got %0d want 4", hs_cnt); else pass_cnt++;
    total_cnt++; if (wdone_cnt != 1) $display("FAIL basic_wdone_cnt got %0d want 1", wdone_cnt); else pass_cnt++;
    total_cnt++; if (wdone_cyc != last_hs_cyc + 1)
      $display("FAIL basic_wdone_time got %0d want %0d", wdone_cyc, last_hs_cyc + 1); else pass_cnt++;
    run_read(32'h0, 32'd16, 0, -1);
    total_cnt++; if (first_valid != start_cyc + 2)
      $display("FAIL basic_latency got %0d want %0d", first_valid, start_cyc + 2); else pass_cnt++;
    total_cnt++; if (rq.size() != 4) $display("FAIL basic_beats got %0d want 4", rq.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      total_cnt++; if (rq[i] !== exp_d[i]) $display("FAIL basic_data%0d got %h want %h", i, rq[i], exp_d[i]); else pass_cnt++;
      total_cnt++; if (lq[i] !== (i == 3)) $display("FAIL basic_last%0d got %b want %b", i, lq[i], i == 3); else pass_cnt++;
    end
    total_cnt++; if (rdone_cnt != 1) $display("FAIL basic_rdone got %0d want 1", rdone_cnt); else pass_cnt++;
  endtask

  task automatic test_read_backpressure;
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
    run_read(32'h0, 32'd16, 1, -1);
    total_cnt++; if (rq.size() != 4) $display("FAIL bp_beats got %0d want 4", rq.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      total_cnt++; if (rq[i] !== exp_d[i]) $display("FAIL bp_data%0d got %h want %h", i, rq[i], exp_d[i]); else pass_cnt++;
    end
    total_cnt++; if (stable_err != 0) $display("FAIL bp_stable got %0d changes want 0", stable_err); else pass_cnt++;
    total_cnt++; if (rq.size() == 4 && lq[3] !== 1'b1) $display("FAIL bp_last got %b want 1", lq[3]); else pass_cnt++;
    total_cnt++; if (rdone_cnt != 1) $display("FAIL bp_rdone got %0d want 1", rdone_cnt); else pass_cnt++;
  endtask

  task automatic test_read_size0;
    run_read(32'h0, 32'd0, 0, -1);
    total_cnt++; if (first_valid != -1) $display("FAIL rd0_tvalid got valid at %0d want none", first_valid); else pass_cnt++;
    total_cnt++; if (rdone_cnt != 1) $display("FAIL rd0_rdone got %0d want 1", rdone_cnt); else pass_cnt++;
  endtask

  task automatic test_write_size0;
    wvec[0] = 32'hDEAD_BEEF;
    run_write(32'h0, 32'd0);
    total_cnt++; if (hs_cnt != 0) $display("FAIL wr0_hs got %0d want 0", hs_cnt); else pass_cnt++;
    total_cnt++; if (wdone_cnt != 1) $display("FAIL wr0_wdone got %0d want 1", wdone_cnt); else pass_cnt++;
  endtask

  task automatic test_read_partial_restart;
    run_read(32'h0, 32'd6, 0, 2);
    total_cnt++; if (rq.size() != 2) $display("FAIL part_beats got %0d want 2", rq.size()); else pass_cnt++;
    total_cnt++; if (rq.size() == 2 && (rq[0] !== 32'h11 || rq[1] !== 32'h22))
      $display("FAIL part_data got %h,%h want 11,22", rq[0], rq[1]); else pass_cnt++;
    total_cnt++; if (rq.size() == 2 && (lq[0] !== 1'b0 || lq[1] !== 1'b1))
      $display("FAIL part_last got %b,%b want 0,1", lq[0], lq[1]); else pass_cnt++;
    total_cnt++; if (rdone_cnt != 1) $display("FAIL part_rdone got %0d want 1", rdone_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_read;
    logic got;
    int   bad_done, bad_valid;
    got = 1'b0; bad_done = 0; bad_valid = 0;
    @(posedge clk); #1;
    ctrl_raddr_offset_i = 32'h0; ctrl_rxfer_size_i = 32'd16; ctrl_rstart_i = 1'b1; rd_tready_i = 1'b1;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (rd_tvalid_o && rd_tready_i) got = 1'b1;
      else begin @(posedge clk); #1 ctrl_rstart_i = 1'b0; end
    end
    total_cnt++; if (!got) $display("FAIL mid_first_beat got none want beat within 10 cycles"); else pass_cnt++;
    @(posedge clk); #1;
    ctrl_rstart_i = 1'b0; rstn = 1'b0;
    @(negedge clk);
    total_cnt++; if ({ctrl_rdone_o, rd_tvalid_o, rd_tlast_o, ctrl_wdone_o, wr_tready_o} !== 5'b0 || rd_tdata_o !== 32'h0)
      $display("FAIL mid_reset_outputs got %b%b%b%b%b data %h want all 0",
               ctrl_rdone_o, rd_tvalid_o, rd_tlast_o, ctrl_wdone_o, wr_tready_o, rd_tdata_o); else pass_cnt++;
    @(posedge clk); #1 rstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ctrl_rdone_o) bad_done++;
      if (rd_tvalid_o) bad_valid++;
    end
    total_cnt++; if (bad_done != 0) $display("FAIL mid_no_done got %0d pulses want 0", bad_done); else pass_cnt++;
    total_cnt++; if (bad_valid != 0) $display("FAIL mid_no_valid got %0d cycles want 0", bad_valid); else pass_cnt++;
    run_read(32'h8, 32'd8, 0, -1);
    total_cnt++; if (rq.size() != 2) $display("FAIL mid_after_beats got %0d want 2", rq.size()); else pass_cnt++;
    total_cnt++; if (rq.size() == 2 && (rq[0] !== 32'h33 || rq[1] !== 32'h44))
      $display("FAIL mid_after_data got %h,%h want 33,44", rq[0], rq[1]); else pass_cnt++;
    total_cnt++; if (rdone_cnt != 1) $display("FAIL mid_after_rdone got %0d want 1", rdone_cnt); else pass_cnt++;
  endtask

  task automatic test_wrap;
    logic [31:0] exp_d [4];
    exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2; exp_d[3] = 32'hA3;
    for (int i = 0; i < 4; i++) wvec[i] = exp_d[i];
    run_write((D - 2) * 4, 32'd16);
    total_cnt++; if (hs_cnt != 4) $display("FAIL wrap_write_hs got %0d want 4", hs_cnt); else pass_cnt++;
    run_read((D - 2) * 4, 32'd16, 0, -1);
    total_cnt++; if (rq.size() != 4) $display("FAIL wrap_beats got %0d want 4", rq.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      total_cnt++; if (rq[i] !== exp_d[i]) $display("FAIL wrap_data%0d got %h want %h", i, rq[i], exp_d[i]); else pass_cnt++;
    end
    run_read(32'h0, 32'd8, 0, -1);
    total_cnt++; if (rq.size() != 2 || rq[0] !== 32'hA2 || rq[1] !== 32'hA3)
      $display("FAIL wrap_low_words got %0d beats want A2,A3", rq.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_write_read_basic;
    test_read_backpressure;
    test_read_size0;
    test_write_size0;
    test_read_partial_restart;
    test_reset_mid_read;
    test_wrap;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
